// File: rtl/rtc_pkg.sv
// Shared constants for the RTC read sweep: register map, display positions, FSM states.
package rtc_pkg;

  localparam int unsigned N_REGS = 9;

  localparam logic [7:0] ADDR_SEG     = 8'h21;
  localparam logic [7:0] ADDR_MIN     = 8'h22;
  localparam logic [7:0] ADDR_HORA    = 8'h23;
  localparam logic [7:0] ADDR_DIA     = 8'h24;
  localparam logic [7:0] ADDR_MES     = 8'h25;
  localparam logic [7:0] ADDR_ANIO    = 8'h26;
  localparam logic [7:0] ADDR_TMR_SEG = 8'h41;
  localparam logic [7:0] ADDR_TMR_MIN = 8'h42;
  localparam logic [7:0] ADDR_TMR_H   = 8'h43;

  localparam logic [3:0] POS_SEG     = 4'd0;
  localparam logic [3:0] POS_MIN     = 4'd1;
  localparam logic [3:0] POS_HORA    = 4'd2;
  localparam logic [3:0] POS_DIA     = 4'd3;
  localparam logic [3:0] POS_MES     = 4'd4;
  localparam logic [3:0] POS_ANIO    = 4'd5;
  localparam logic [3:0] POS_TMR_SEG = 4'd6;
  localparam logic [3:0] POS_TMR_MIN = 4'd7;
  localparam logic [3:0] POS_TMR_H   = 4'd8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIR     = 3'd1,
    ESP1    = 3'd2,
    DATO    = 3'd3,
    ESP2    = 3'd4,
    PUBLICA = 3'd5
  } estado_t;

  // Display position -> RTC register address.
  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      POS_SEG:     reg_addr = ADDR_SEG;
      POS_MIN:     reg_addr = ADDR_MIN;
      POS_HORA:    reg_addr = ADDR_HORA;
      POS_DIA:     reg_addr = ADDR_DIA;
      POS_MES:     reg_addr = ADDR_MES;
      POS_ANIO:    reg_addr = ADDR_ANIO;
      POS_TMR_SEG: reg_addr = ADDR_TMR_SEG;
      POS_TMR_MIN: reg_addr = ADDR_TMR_MIN;
      POS_TMR_H:   reg_addr = ADDR_TMR_H;
      default:     reg_addr = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Free-running 0..CICLOS-1 counter; tick is high for the one cycle the counter sits at its last value.
module divisor_tick #(
  parameter int unsigned CICLOS = 1_666_667
) (
  input  logic reloj,
  input  logic resetM,
  output logic tick
);

  localparam int unsigned W = (CICLOS > 1) ? $clog2(CICLOS) : 1;
  localparam logic [W-1:0] ULTIMO = W'(CICLOS - 1);

  logic [W-1:0] cuenta;

  always_ff @(posedge reloj) begin
    if (!resetM) begin
      cuenta <= '0;
    end else if (cuenta == ULTIMO) begin
      cuenta <= '0;
    end else begin
      cuenta <= cuenta + 1'b1;
    end
  end

  assign tick = (cuenta == ULTIMO);

endmodule

// File: rtl/rtc_lectura_sec.sv
// Periodic nine-register read sweep of the RTC multiplexed AD bus, publishing one
// DIR_DATO/POSICION/RD strobe per register to the display path.
module rtc_lectura_sec
  import rtc_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 1_666_667,
  parameter int unsigned T_PULSE     = 10,
  parameter int unsigned T_GAP       = 5
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       pausa,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] DIR_DATO,
  output logic [3:0] POSICION,
  output logic       RD,
  output logic       ocupado
);

  localparam int unsigned T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int unsigned FW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [FW-1:0] FIN_PULSO = FW'(T_PULSE - 1);
  localparam logic [FW-1:0] FIN_GAP   = FW'(T_GAP - 1);

  estado_t       estado;
  logic [FW-1:0] fase;
  logic [3:0]    indice;
  logic [7:0]    dato_cap;
  logic          pendiente;
  logic          tick;

  divisor_tick #(
    .CICLOS (TICK_CYCLES)
  ) u_divisor (
    .reloj  (reloj),
    .resetM (resetM),
    .tick   (tick)
  );

  always_ff @(posedge reloj) begin
    if (!resetM) begin
      estado    <= IDLE;
      fase      <= '0;
      indice    <= '0;
      dato_cap  <= '0;
      pendiente <= 1'b0;
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      a_d       <= 1'b1;
      ad_oe     <= 1'b0;
      ad_out    <= '0;
      DIR_DATO  <= '0;
      POSICION  <= '0;
      RD        <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      // A wrap that finds a request already pending is simply absorbed.
      if (tick) begin
        pendiente <= 1'b1;
      end
      RD <= 1'b0;

      case (estado)
        IDLE: begin
          if (pendiente && !pausa) begin
            // Consuming the request wins over a wrap on the same edge.
            pendiente <= 1'b0;
            indice    <= POS_SEG;
            fase      <= '0;
            estado    <= DIR;
            cs_n      <= 1'b0;
            wr_n      <= 1'b0;
            a_d       <= 1'b0;
            ad_oe     <= 1'b1;
            ad_out    <= reg_addr(POS_SEG);
            ocupado   <= 1'b1;
          end
        end

        DIR: begin
          if (fase == FIN_PULSO) begin
            fase   <= '0;
            estado <= ESP1;
            cs_n   <= 1'b1;
            wr_n   <= 1'b1;
            a_d    <= 1'b1;
          end else begin
            fase <= fase + 1'b1;
          end
        end

        ESP1: begin
          if (fase == FIN_GAP) begin
            // Release the bus on the same edge the read strobe falls.
            fase   <= '0;
            estado <= DATO;
            cs_n   <= 1'b0;
            rd_n   <= 1'b0;
            ad_oe  <= 1'b0;
          end else begin
            fase <= fase + 1'b1;
          end
        end

        DATO: begin
          if (fase == FIN_PULSO) begin
            dato_cap <= ad_in;
            fase     <= '0;
            estado   <= ESP2;
            cs_n     <= 1'b1;
            rd_n     <= 1'b1;
          end else begin
            fase <= fase + 1'b1;
          end
        end

        ESP2: begin
          if (fase == FIN_GAP) begin
            fase     <= '0;
            estado   <= PUBLICA;
            RD       <= 1'b1;
            DIR_DATO <= dato_cap;
            POSICION <= indice;
          end else begin
            fase <= fase + 1'b1;
          end
        end

        PUBLICA: begin
          if (indice == POS_TMR_H) begin
            estado  <= IDLE;
            ocupado <= 1'b0;
          end else begin
            indice <= indice + 4'd1;
            fase   <= '0;
            estado <= DIR;
            cs_n   <= 1'b0;
            wr_n   <= 1'b0;
            a_d    <= 1'b0;
            ad_oe  <= 1'b1;
            ad_out <= reg_addr(indice + 4'd1);
          end
        end

        default: begin
          estado <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_lectura_sec.sv
// Randomized bench for rtc_lectura_sec: cycle-timed reference model plus RD scoreboard.
module tb_rtc_lectura_sec;

  localparam int TICK    = 40;
  localparam int TP      = 2;
  localparam int TG      = 1;
  localparam int REG_CYC = 2*TP + 2*TG + 1;
  localparam int SWEEP   = 9 * REG_CYC;

  logic       reloj = 1'b0;
  logic       resetM = 1'b0;
  logic       pausa = 1'b0;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d, RD, ocupado;
  logic [7:0] DIR_DATO;
  logic [3:0] POSICION;

  always #5 reloj = ~reloj;

  rtc_lectura_sec #(
    .TICK_CYCLES (TICK),
    .T_PULSE     (TP),
    .T_GAP       (TG)
  ) dut (
    .reloj    (reloj),
    .resetM   (resetM),
    .pausa    (pausa),
    .ad_in    (ad_in),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .cs_n     (cs_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .a_d      (a_d),
    .DIR_DATO (DIR_DATO),
    .POSICION (POSICION),
    .RD       (RD),
    .ocupado  (ocupado)
  );

  logic [7:0] addr_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] lit      [9] = '{8'hDE, 8'hDD, 8'hDC, 8'hDB, 8'hDA, 8'hD9, 8'hBE, 8'hBD, 8'hBC};

  // RTC chip model: latches the address on a write strobe, returns its memory contents.
  logic [7:0] mem [0:255];
  logic [7:0] latch = 8'h00;
  always @(posedge reloj) if (!cs_n && !wr_n) latch <= ad_out;
  assign ad_in = mem[latch];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  // Reference model: sweep timeline from arithmetic on edge counts since reset release.
  typedef struct { int pos; logic [7:0] dato; } ev_t;
  ev_t sb [$];

  int         m_n, m_s, m_rel, m_o, m_i;
  bit         m_act, m_pend, armed, m_idle_before, m_wrap;
  logic       e_cs, e_rd, e_wr, e_ad, e_oe, e_rdp;
  logic [7:0] m_cap, m_out, m_dato;
  logic [3:0] m_pos;
  logic [26:0] m_exp;
  ev_t        m_ev;

  always @(posedge reloj) begin
    if (!resetM) begin
      m_n = 0; m_act = 0; m_pend = 0;
      m_out = 8'h00; m_dato = 8'h00; m_pos = 4'h0;
      m_exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0};
      armed = 1;
    end else begin
      m_n++;
      m_wrap = (m_n % TICK) == 0;
      m_idle_before = !m_act;
      if (m_act && (m_n - m_s) == SWEEP) m_act = 0;
      if (m_idle_before && m_pend && !pausa) begin
        m_act = 1; m_s = m_n; m_pend = 0;
      end else if (m_wrap) begin
        m_pend = 1;
      end
      e_cs = 1; e_rd = 1; e_wr = 1; e_ad = 1; e_oe = 0; e_rdp = 0;
      if (m_act) begin
        m_rel = m_n - m_s;
        m_o = m_rel % REG_CYC;
        m_i = m_rel / REG_CYC;
        if (m_o < TP) begin
          e_cs = 0; e_wr = 0; e_ad = 0; e_oe = 1; m_out = addr_tab[m_i];
        end else if (m_o < TP + TG) begin
          e_oe = 1;
        end else if (m_o < 2*TP + TG) begin
          e_cs = 0; e_rd = 0;
        end
        if (m_o == 2*TP + TG) m_cap = mem[addr_tab[m_i]];
        if (m_o == 2*TP + 2*TG) begin
          e_rdp = 1; m_dato = m_cap; m_pos = m_i[3:0];
          m_ev.pos = m_i; m_ev.dato = m_cap;
          sb.push_back(m_ev);
        end
      end
      m_exp = {e_cs, e_rd, e_wr, e_ad, e_oe, m_out, m_dato, m_pos, e_rdp, m_act};
    end
  end

  // Monitor: whole output vector every cycle, RD events against the scoreboard.
  int   nrd = 0;
  ev_t  got_ev;
  always @(negedge reloj) begin
    if (armed) begin
      chk("bus_outputs", {5'h0, cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, DIR_DATO, POSICION, RD, ocupado},
          {5'h0, m_exp});
      chk("cs_strobe_excl", {31'h0, (!wr_n && !rd_n) || (!rd_n && ad_oe)}, 32'h0);
      if (RD) begin
        if (sb.size() == 0) begin
          chk("rd_unexpected", 32'h1, 32'h0);
        end else begin
          got_ev = sb.pop_front();
          chk("posicion", {28'h0, POSICION}, got_ev.pos);
          chk("dir_dato", {24'h0, DIR_DATO}, {24'h0, got_ev.dato});
          if (nrd < 9) chk("first_sweep_dato", {24'h0, DIR_DATO}, {24'h0, lit[nrd]});
          nrd++;
        end
      end
    end
  end

  task automatic wait_rel(input int r);
    bit hit = 0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      @(posedge reloj); #2;
      hit = m_act && ((m_n - m_s) == r);
    end
    chk("wait_rel_timeout", {31'h0, hit}, 32'h1);
  endtask

  task automatic wait_idle();
    bit hit = 0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      @(posedge reloj); #2;
      hit = !m_act;
    end
    chk("wait_idle_timeout", {31'h0, hit}, 32'h1);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hFF;
    resetM = 1'b0;
    pausa  = 1'b0;
    repeat (3) @(posedge reloj);
    #2 resetM = 1'b1;

    // Two natural sweeps, the second fed by a tick that landed mid-sweep.
    repeat (200) @(posedge reloj);

    // Hold pausa across the end of a sweep with a request pending.
    wait_rel(0);
    pausa = 1'b1;
    wait_idle();
    repeat (50) @(posedge reloj);
    #2 pausa = 1'b0;

    // pausa raised mid-index-4 must not disturb the running sweep.
    wait_rel(4*REG_CYC + 3);
    pausa = 1'b1;
    wait_idle();
    repeat (10) @(posedge reloj);
    #2 pausa = 1'b0;

    // One-cycle reset during the DATO phase of index 3.
    wait_rel(3*REG_CYC + TP + TG);
    resetM = 1'b0;
    @(posedge reloj); #2;
    resetM = 1'b1;

    // Random pausa, RTC contents and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(posedge reloj); #2;
      if ($urandom_range(0, 99) < 3) pausa = ~pausa;
      if ($urandom_range(0, 3) == 0) mem[addr_tab[$urandom_range(0, 8)]] = 8'($urandom);
      resetM = ($urandom_range(0, 299) != 0);
    end
    resetM = 1'b1;
    pausa  = 1'b0;
    repeat (150) @(posedge reloj);

    @(negedge reloj); #1;
    chk("scoreboard_empty", sb.size(), 32'h0);
    chk("first_sweep_seen", {31'h0, nrd >= 9}, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_lectura_sec.md
# rtc_lectura_sec

Periodic read sequencer between the external real-time-clock chip and the VGA display path. On every refresh tick it walks a fixed list of nine RTC registers (date, time, countdown timer) over the RTC's multiplexed address/data bus. After each register read it publishes one `DIR_DATO`/`POSICION`/`RD` strobe to the font-ROM stage. It is the direct upstream producer of those three signals.

## Interface
Parameters:
- `TICK_CYCLES`, default 1_666_667: `reloj` cycles between sweep requests (60 Hz at 100 MHz).
- `T_PULSE`, default 10: cycles each strobe phase (address, data) is held; ≥1.
- `T_GAP`, default 5: idle cycles after each strobe phase; ≥1.

Ports:
- `reloj`, in, 1: single clock.
- `resetM`, in, 1: synchronous, active-low reset.
- `pausa`, in, 1: bus owned by the write/programming controller; blocks the start of a new sweep.
- `ad_in`, in, 8: data from the RTC AD bus.
- `ad_out`, out, 8: address driven onto the AD bus.
- `ad_oe`, out, 1: AD bus output enable (1 = drive `ad_out`).
- `cs_n`, out, 1: RTC chip select, active-low.
- `rd_n`, out, 1: RTC read strobe, active-low.
- `wr_n`, out, 1: RTC write strobe, active-low.
- `a_d`, out, 1: 0 = address phase, 1 = data phase.
- `DIR_DATO`, out, 8: last register value read (BCD, unmodified).
- `POSICION`, out, 4: index 0..8 of that register.
- `RD`, out, 1: one-cycle "new data" pulse to the display.
- `ocupado`, out, 1: sweep in progress.

## Operation
- Register list, indices 0..8: 0x21 s, 0x22 min, 0x23 h, 0x24 day, 0x25 month, 0x26 year, 0x41 timer s, 0x42 timer min, 0x43 timer h.
- Tick counter free-runs 0..`TICK_CYCLES`-1. On wrap it sets `pendiente`. A wrap while `pendiente` is already set is dropped; requests are not queued.
- FSM states: `IDLE`, `DIR`, `ESP1`, `DATO`, `ESP2`, `PUBLICA`.
- `IDLE`:
  - Moves to `DIR` when `pendiente`=1 and `pausa`=0.
  - Clears `pendiente` and sets index=0 on that transition.
  - `pausa`=1 holds the FSM in `IDLE` with `pendiente` kept.
- `DIR`, `T_PULSE` cycles: `cs_n`=0, `wr_n`=0, `a_d`=0, `ad_oe`=1, `ad_out`=address[index].
- `ESP1`, `T_GAP` cycles: `cs_n`=`rd_n`=`wr_n`=1, `ad_oe`=1, `a_d`=1. `ad_out` holds its value.
- `DATO`, `T_PULSE` cycles:
  - `cs_n`=0, `rd_n`=0, `a_d`=1, `ad_oe`=0.
  - `ad_in` is registered on the last `DATO` cycle.
- `ESP2`, `T_GAP` cycles: all strobes high, `ad_oe`=0.
- `PUBLICA`, 1 cycle:
  - `RD`=1.
  - `DIR_DATO` = the captured byte and `POSICION` = index, both registered and held until the next `PUBLICA`.
  - If index=8, go to `IDLE`. Otherwise increment index and go to `DIR`.
- `pausa` is sampled only in `IDLE`. A sweep, once started, always completes.
- `ocupado` = 1 in every state except `IDLE`.

## Timing
- All outputs are registered and change only on the rising edge of `reloj`.
- Reset values:
  - `cs_n`=`rd_n`=`wr_n`=1, `a_d`=1, `ad_oe`=0, `ad_out`=0.
  - `DIR_DATO`=0, `POSICION`=0, `RD`=0, `ocupado`=0.
  - FSM=`IDLE`, `pendiente`=0, tick counter=0, index=0.
- Reset asserted mid-sweep: the next edge forces the reset values. No partial `RD` pulse is emitted and the sweep is not resumed.
- `DIR` entry to `RD` pulse = 2·`T_PULSE`+2·`T_GAP` cycles. One register takes 2·`T_PULSE`+2·`T_GAP`+1 cycles (31 at defaults); a full sweep takes 9× that (279).
- First tick after reset occurs `TICK_CYCLES` cycles after reset release. `DIR` starts one cycle after `pendiente` is seen with `pausa`=0.
- `cs_n` is never low in two consecutive phases: each `ESP` state separates the strobes.
- `ad_oe` falls at the `ESP1`→`DATO` edge, the same edge where `rd_n` falls.
- A tick that lands during a sweep sets `pendiente`. A second sweep then starts one cycle after `PUBLICA` of index 8 (through `IDLE`).

## Structure
- Package `rtc_pkg` holds:
  - the 9-entry register address list (8-bit constants);
  - the `POSICION` encoding constants (0..8);
  - the FSM state enum.
- One sub-module, `divisor_tick`: the parameterised free-running counter with a one-cycle wrap pulse.
- Phase counter width = clog2(max(`T_PULSE`,`T_GAP`)).

## Test plan
- Reset, then `TICK_CYCLES`=100, `T_PULSE`=2, `T_GAP`=1, `ad_in` model returns the address XOR 0xFF → nine `RD` pulses, each 7 cycles apart. `POSICION` runs 0..8 and `DIR_DATO` runs 0xDE,0xDD,0xDC,0xDB,0xDA,0xD9,0xBE,0xBD,0xBC.
- Bus protocol checker over the whole sweep:
  - `cs_n` low only during `DIR`/`DATO`;
  - `wr_n` and `rd_n` never low together;
  - `ad_oe`=0 whenever `rd_n`=0;
  - `ad_out`=0x21 during the first `DIR`.
- Hold `pausa`=1 across the tick for 50 cycles → no strobes and `ocupado`=0. After release, `DIR` starts 1 cycle later.
- Raise `pausa` in the middle of index 4 → the sweep finishes through index 8 unchanged.
- Assert `resetM`=0 for 1 cycle during the `DATO` phase of index 3 → all outputs return to reset values the next cycle, with no `RD` pulse for index 3.
- `TICK_CYCLES`=40 (shorter than a sweep) → back-to-back sweeps with exactly one `IDLE` cycle between them. Extra ticks are dropped, never queued.
